// File: rtl/mem_dump_unit_if.sv
// Memory read port and UART TX handshake used by the memory dump unit.
// The master modport is the dump unit side; slave is memory plus UART.
interface mem_dump_unit_if #(
   parameter int ADDR_LENGTH = 32
);
   logic [ADDR_LENGTH-1:0] o_Addr;
   logic                   o_Re;
   logic                   o_We;
   logic [4:0]             o_size_control;
   logic [31:0]            i_Data;
   logic [7:0]             o_tx_data;
   logic                   o_tx_start;
   logic                   i_tx_done;

   modport master (
      output o_Addr, o_Re, o_We, o_size_control, o_tx_data, o_tx_start,
      input  i_Data, i_tx_done
   );

   modport slave (
      input  o_Addr, o_Re, o_We, o_size_control, o_tx_data, o_tx_start,
      output i_Data, i_tx_done
   );
endinterface

// File: rtl/mem_dump_unit.sv
// Walks data memory words 0..DUMP_WORDS-1 and streams each word MSB byte first
// to the UART transmitter; all outputs are registered from the next-state values.
module mem_dump_unit #(
   parameter int DUMP_WORDS  = 1024,
   parameter int ADDR_LENGTH = 32,
   parameter int DATA_LENGTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   mem_dump_unit_if.master  bus,
   output logic             o_busy,
   output logic             o_done
);
   localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_LATCH   = 3'd2,
      S_SEND    = 3'd3,
      S_WAIT_TX = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         word_idx_q, word_idx_d;
   logic [1:0]               byte_idx_q, byte_idx_d;
   logic [DATA_LENGTH-1:0]   word_buf_q, word_buf_d;
   logic [ADDR_LENGTH-1:0]   addr_q, addr_d;
   logic                     re_q, re_d;
   logic [7:0]               tx_data_q, tx_data_d;
   logic                     tx_start_q, tx_start_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         2'd3:    b = w[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Next-state logic, then outputs decoded from the next state so they register in step
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      word_buf_d = word_buf_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d    = S_REQ;
               word_idx_d = '0;
               byte_idx_d = 2'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ:   state_d = S_LATCH;
         S_LATCH: begin
            word_buf_d = bus.i_Data;
            state_d    = S_SEND;
         end
         S_SEND:  state_d = S_WAIT_TX;
         S_WAIT_TX: begin
            if (!bus.i_tx_done) begin
               state_d = S_WAIT_TX;
            end else if (byte_idx_q != 2'd3) begin
               byte_idx_d = byte_idx_q + 2'd1;
               state_d    = S_SEND;
            end else if (word_idx_q != LAST_IDX) begin
               word_idx_d = word_idx_q + IDX_W'(1);
               byte_idx_d = 2'd0;
               state_d    = S_REQ;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      addr_d     = '0;
      re_d       = 1'b0;
      tx_data_d  = 8'h00;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
      busy_d     = (state_d != S_IDLE);
      case (state_d)
         S_REQ, S_LATCH: begin
            re_d   = 1'b1;
            addr_d = ADDR_LENGTH'(word_idx_d);
         end
         S_SEND: begin
            tx_start_d = 1'b1;
            tx_data_d  = sel_byte(word_buf_d, byte_idx_d);
         end
         S_WAIT_TX: tx_data_d = sel_byte(word_buf_d, byte_idx_d);
         S_DONE:    done_d = 1'b1;
         default:   done_d = 1'b0;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= S_IDLE;
         word_idx_q <= '0;
         byte_idx_q <= 2'd0;
         word_buf_q <= '0;
         addr_q     <= '0;
         re_q       <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         word_buf_q <= word_buf_d;
         addr_q     <= addr_d;
         re_q       <= re_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.o_Addr         = addr_q;
   assign bus.o_Re           = re_q;
   assign bus.o_We           = 1'b0;
   assign bus.o_size_control = 5'b00000;
   assign bus.o_tx_data      = tx_data_q;
   assign bus.o_tx_start     = tx_start_q;
   assign o_busy             = busy_q;
   assign o_done             = done_q;
endmodule

// File: tb/tb_mem_dump_unit.sv
// Bench for mem_dump_unit with a two-word memory, a UART model with programmable
// done delay, and byte/address scoreboards filled when each dump is launched.
`timescale 1ns/1ps
module tb_mem_dump_unit;
   localparam int N = 2;

   typedef struct {
      logic [31:0] w0;
      logic [31:0] w1;
      int          delay;
      int          exp_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        tx_done_auto;
   logic        tx_stray;
   logic [31:0] mem [0:N-1];
   logic [31:0] rdata;
   int          errors = 0;
   int          checks = 0;
   int          tx_delay = 1;
   int          done_cnt = 0;
   logic [7:0]  exp_bytes [$];
   logic [31:0] exp_addrs [$];
   vec_t        vecs [4];

   mem_dump_unit_if #(.ADDR_LENGTH(32)) bus ();

   mem_dump_unit #(.DUMP_WORDS(N), .ADDR_LENGTH(32), .DATA_LENGTH(32)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .bus     (bus),
      .o_busy  (busy),
      .o_done  (done)
   );

   always #5 clk = ~clk;

   assign bus.i_tx_done = tx_done_auto | tx_stray;
   assign bus.i_Data    = rdata;

   always @(posedge clk) begin
      if (bus.o_Re === 1'b1) rdata <= mem[bus.o_Addr[0]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {14'd0, bus.o_Addr, bus.o_Re, bus.o_We, bus.o_size_control,
              bus.o_tx_data, bus.o_tx_start, busy, done};
   endfunction

   task automatic push_dump();
      logic [31:0] w;
      for (int wi = 0; wi < N; wi++) begin
         w = mem[wi];
         exp_addrs.push_back(32'(wi));
         exp_addrs.push_back(32'(wi));
         for (int b = 0; b < 4; b++) exp_bytes.push_back(w[31 - 8*b -: 8]);
      end
   endtask

   // UART model: done pulse tx_delay cycles after each start
   initial begin
      int cnt;
      cnt = 0;
      tx_done_auto = 1'b0;
      forever begin
         @(negedge clk);
         tx_done_auto = 1'b0;
         if (rst !== 1'b1) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) tx_done_auto = 1'b1;
            end
            if (bus.o_tx_start === 1'b1) cnt = tx_delay;
         end
      end
   end

   // Output monitor and scoreboard consumer
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            check("we_size_zero", {58'd0, bus.o_We, bus.o_size_control}, 64'd0);
            if (bus.o_tx_start === 1'b1) begin
               if (exp_bytes.size() == 0) check("unexpected_byte", {56'd0, bus.o_tx_data}, 64'hFFFF);
               else check("tx_byte", {56'd0, bus.o_tx_data}, {56'd0, exp_bytes.pop_front()});
            end
            if (bus.o_Re === 1'b1) begin
               if (exp_addrs.size() == 0) check("unexpected_read", {32'd0, bus.o_Addr}, 64'hFFFF_FFFF_FFFF);
               else check("read_addr", {32'd0, bus.o_Addr}, {32'd0, exp_addrs.pop_front()});
            end
            if (done === 1'b1) done_cnt++;
         end
      end
   end

   task automatic run_dump(input int d, input int exp_lat, input bit inj);
      int lat;
      int busy_cyc;
      int starts_seen;
      int since;
      lat = -1;
      busy_cyc = 0;
      starts_seen = 0;
      since = 0;
      tx_delay = d;
      done_cnt = 0;
      push_dump();
      if (inj) begin
         @(negedge clk);
         tx_stray = 1'b1;
         @(negedge clk);
         tx_stray = 1'b0;
         check("idle_stray_busy", {63'd0, busy}, 64'd0);
      end
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = 1'b0;
         tx_stray = 1'b0;
         if (busy === 1'b1) busy_cyc++;
         if (bus.o_tx_start === 1'b1) begin
            starts_seen++;
            since = 0;
         end else begin
            since++;
         end
         if (inj && bus.o_tx_start === 1'b1 && starts_seen == 2) tx_stray = 1'b1;
         if (inj && starts_seen == 3 && since == 1) start = 1'b1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("done_latency", 64'(lat), 64'(exp_lat));
      check("busy_cycles", 64'(busy_cyc), 64'(exp_lat));
      @(negedge clk);
      check("idle_after_done", {62'd0, busy, done}, 64'd0);
      check("done_count", 64'(done_cnt), 64'd1);
      check("bytes_left", 64'(exp_bytes.size()), 64'd0);
      check("addrs_left", 64'(exp_addrs.size()), 64'd0);
   endtask

   initial begin
      int starts_seen;
      vecs[0] = '{w0: 32'h11223344, w1: 32'hA5A50F0F, delay: 3, exp_lat: 37};
      vecs[1] = '{w0: 32'h11223344, w1: 32'hA5A50F0F, delay: 1, exp_lat: 21};
      vecs[2] = '{w0: 32'hFFFFFFFF, w1: 32'h00000000, delay: 2, exp_lat: 29};
      vecs[3] = '{w0: 32'h80000001, w1: 32'h01020304, delay: 1, exp_lat: 21};

      rst = 1'b0;
      start = 1'b0;
      tx_stray = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         start = ~start;
         tx_stray = ~tx_stray;
         @(negedge clk);
         check("reset_outputs", all_outputs(), 64'd0);
      end
      start = 1'b0;
      tx_stray = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_idle", all_outputs(), 64'd0);

      for (int v = 0; v < 4; v++) begin
         mem[0] = vecs[v].w0;
         mem[1] = vecs[v].w1;
         run_dump(vecs[v].delay, vecs[v].exp_lat, 1'b0);
      end

      mem[0] = 32'h11223344;
      mem[1] = 32'hA5A50F0F;
      run_dump(3, 37, 1'b1);

      // Abort in WAIT_TX of word 1 byte 1 (sixth byte)
      tx_delay = 3;
      done_cnt = 0;
      starts_seen = 0;
      push_dump();
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (bus.o_tx_start === 1'b1) begin
            starts_seen++;
         end else if (starts_seen == 6) begin
            rst = 1'b0;
            break;
         end
      end
      check("abort_reached", 64'(starts_seen), 64'd6);
      @(negedge clk);
      check("abort_outputs", all_outputs(), 64'd0);
      rst = 1'b1;
      exp_bytes.delete();
      exp_addrs.delete();
      repeat (10) @(negedge clk);
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_idle", {63'd0, busy}, 64'd0);

      run_dump(1, 21, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
